// File: rtl/mem_arbiter_if.sv
// Request port of the memory arbiter: one requester (master)
// talking to one arbiter input (slave).
interface mem_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              uds;
  logic              lds;
  logic              rw;
  logic              ack;
  logic              err;
  logic [15:0]       rdata;

  modport master (
    output req, addr, wdata, uds, lds, rw,
    input  ack, err, rdata
  );

  modport slave (
    input  req, addr, wdata, uds, lds, rw,
    output ack, err, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and bus sequencer for the
// 16-bit word memory: setup, strobe and release phases.
module mem_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_uds,
  output logic              mem_lds,
  output logic              mem_rw,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        gnt;
  logic        uds_q;
  logic        lds_q;
  logic [7:0]  cnt;

  logic        pick1;
  logic        fin;
  logic        fin_err;
  logic [15:0] fin_data;

  // On a tie the port that did not win last time goes first
  assign pick1 = m1.req & (~m0.req | ~last_grant);

  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = mem_rdata;
    if (state == STROBE) begin
      fin     = mem_ack | (cnt == 8'(TIMEOUT - 1));
      fin_err = ~mem_ack;
      if (!mem_ack) fin_data = 16'hFFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      uds_q      <= 1'b0;
      lds_q      <= 1'b0;
      cnt        <= 8'd0;
      mem_addr   <= '0;
      mem_wdata  <= 16'h0000;
      mem_uds    <= 1'b0;
      mem_lds    <= 1'b0;
      mem_rw     <= 1'b1;
      m0.ack     <= 1'b0;
      m0.err     <= 1'b0;
      m0.rdata   <= 16'h0000;
      m1.ack     <= 1'b0;
      m1.err     <= 1'b0;
      m1.rdata   <= 16'h0000;
    end else begin
      m0.ack <= 1'b0;
      m0.err <= 1'b0;
      m1.ack <= 1'b0;
      m1.err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (m0.req || m1.req) begin
            gnt        <= pick1;
            last_grant <= pick1;
            mem_addr   <= pick1 ? m1.addr  : m0.addr;
            mem_wdata  <= pick1 ? m1.wdata : m0.wdata;
            mem_rw     <= pick1 ? m1.rw    : m0.rw;
            uds_q      <= pick1 ? m1.uds   : m0.uds;
            lds_q      <= pick1 ? m1.lds   : m0.lds;
            state      <= SETUP;
          end
        end
        SETUP: begin
          mem_uds <= uds_q;
          mem_lds <= lds_q;
          state   <= STROBE;
        end
        STROBE: begin
          if (fin) begin
            mem_uds <= 1'b0;
            mem_lds <= 1'b0;
            mem_rw  <= 1'b1;
            state   <= DONE;
            if (gnt) begin
              m1.ack   <= 1'b1;
              m1.err   <= fin_err;
              m1.rdata <= fin_data;
            end else begin
              m0.ack   <= 1'b1;
              m0.err   <= fin_err;
              m0.rdata <= fin_data;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          mem_rw <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a strobe-edge
// triggered word memory model.
module tb_mem_arbiter;

  localparam int ADDR_W  = 24;
  localparam int TIMEOUT = 16;
  localparam int MEM_N   = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_uds;
  logic              mem_lds;
  logic              mem_rw;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) m0 ();
  mem_arbiter_if #(.ADDR_W(ADDR_W)) m1 ();

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0       (m0),
    .m1       (m1),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_uds  (mem_uds),
    .mem_lds  (mem_lds),
    .mem_rw   (mem_rw),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:MEM_N-1];
  logic        prev_stb;
  logic        in_range;
  logic        stb;

  assign in_range  = (mem_addr < ADDR_W'(MEM_N));
  assign stb       = mem_uds | mem_lds;
  assign mem_rdata = in_range ? mem[mem_addr[9:0]] : 16'hDEAD;

  always @(posedge clk) begin
    prev_stb <= stb;
    mem_ack  <= in_range && (mem_rw || (stb && !prev_stb));
    if (!mem_rw && in_range && stb && !prev_stb) begin
      if (mem_uds) mem[mem_addr[9:0]][15:8] <= mem_wdata[15:8];
      if (mem_lds) mem[mem_addr[9:0]][7:0]  <= mem_wdata[7:0];
    end
  end

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int low_run = 1000;
  int min_gap = 1000;
  logic prev_n = 1'b0;

  always @(negedge clk) begin
    if (m0.ack === 1'b1 && m1.ack === 1'b1) overlap++;
    if (stb && !prev_n && low_run < min_gap) min_gap = low_run;
    low_run = stb ? 0 : low_run + 1;
    prev_n  = stb;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic q,
                       input logic [23:0] a, input logic [15:0] wd,
                       input logic u, input logic l, input logic r);
    if (p == 0) begin
      m0.req = q; m0.addr = a; m0.wdata = wd;
      m0.uds = u; m0.lds = l; m0.rw = r;
    end else begin
      m1.req = q; m1.addr = a; m1.wdata = wd;
      m1.uds = u; m1.lds = l; m1.rw = r;
    end
  endtask

  task automatic txn(input int p, input logic [23:0] a,
                     input logic [15:0] wd, input logic u,
                     input logic l, input logic r, output int lat,
                     output logic e, output logic [15:0] rd);
    logic ak;
    @(posedge clk);
    @(negedge clk);
    drive(p, 1'b1, a, wd, u, l, r);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      ak = (p == 0) ? m0.ack : m1.ack;
    end while (ak !== 1'b1 && lat < 100);
    if (ak !== 1'b1) chk("txn_wait", 32'(ak), 32'd1);
    e  = (p == 0) ? m0.err : m1.err;
    rd = (p == 0) ? m0.rdata : m1.rdata;
    drive(p, 1'b0, a, wd, u, l, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic port_loop(input int p, input logic [23:0] a,
                           input logic [15:0] exp, ref int q[$]);
    int n;
    logic ak;
    for (int k = 0; k < 2; k++) begin
      drive(p, 1'b1, a, 16'h0, 1'b1, 1'b1, 1'b1);
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
        ak = (p == 0) ? m0.ack : m1.ack;
      end while (ak !== 1'b1 && n < 50);
      if (ak !== 1'b1) chk("rr_wait", 32'(ak), 32'd1);
      q.push_back(p);
      chk("rr_rdata", 32'((p == 0) ? m0.rdata : m1.rdata), 32'(exp));
      drive(p, 1'b0, a, 16'h0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
    end
  endtask

  int          lat;
  logic        e;
  logic [15:0] rd;
  int          order[$];

  initial begin
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'hC000 | 16'(i);
    drive(0, 1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rw", 32'(mem_rw), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_strobes", 32'({mem_uds, mem_lds}), 32'd0);
    chk("rst_acks", 32'({m0.ack, m1.ack, m0.err, m1.err}), 32'd0);
    chk("rst_rdata", 32'({m0.rdata, m1.rdata}), 32'd0);
    reset = 1'b0;

    txn(0, 24'd5, 16'hA55A, 1'b1, 1'b0, 1'b0, lat, e, rd);
    chk("wr1_lat", 32'(lat), 32'd4);
    chk("wr1_err", 32'(e), 32'd0);
    txn(0, 24'd5, 16'h1234, 1'b0, 1'b1, 1'b0, lat, e, rd);
    chk("wr2_lat", 32'(lat), 32'd4);
    txn(0, 24'd5, 16'h0, 1'b1, 1'b1, 1'b1, lat, e, rd);
    chk("rd5_lat", 32'(lat), 32'd3);
    chk("rd5_err", 32'(e), 32'd0);
    chk("rd5_data", 32'(rd), 32'h0000A534);
    chk("mem5", 32'(mem[5]), 32'h0000A534);

    do_reset();
    @(negedge clk);
    fork
      port_loop(0, 24'd10, 16'hC00A, order);
      port_loop(1, 24'd20, 16'hC014, order);
    join
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("rr_order", 32'(order[i]), 32'(i % 2));

    txn(1, 24'h002000, 16'h0, 1'b1, 1'b1, 1'b1, lat, e, rd);
    chk("to_lat", 32'(lat), 32'(TIMEOUT + 2));
    chk("to_err", 32'(e), 32'd1);
    chk("to_rdata", 32'(rd), 32'h0000FFFF);
    txn(0, 24'd20, 16'h0, 1'b1, 1'b1, 1'b1, lat, e, rd);
    chk("after_to_lat", 32'(lat), 32'd3);
    chk("after_to_err", 32'(e), 32'd0);
    chk("after_to_data", 32'(rd), 32'h0000C014);

    txn(0, 24'd7, 16'h5555, 1'b0, 1'b0, 1'b0, lat, e, rd);
    chk("noen_lat", 32'(lat), 32'(TIMEOUT + 2));
    chk("noen_err", 32'(e), 32'd1);
    chk("noen_mem", 32'(mem[7]), 32'h0000C007);

    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 24'd10, 16'h0, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ack", 32'({m0.ack, m0.err}), 32'd0);
    chk("rst_mid_rw", 32'(mem_rw), 32'd1);
    chk("rst_mid_addr", 32'(mem_addr), 32'd0);
    chk("rst_mid_stb", 32'({mem_uds, mem_lds}), 32'd0);
    chk("rst_mid_rdata", 32'(m0.rdata), 32'd0);
    drive(0, 1'b0, 24'd10, 16'h0, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    txn(0, 24'd10, 16'h0, 1'b1, 1'b1, 1'b1, lat, e, rd);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", 32'(rd), 32'h0000C00A);

    min_gap = 1000;
    txn(0, 24'd9, 16'hABFF, 1'b1, 1'b0, 1'b0, lat, e, rd);
    chk("gap_wr1_err", 32'(e), 32'd0);
    txn(0, 24'd9, 16'hFFCD, 1'b0, 1'b1, 1'b0, lat, e, rd);
    chk("gap_wr2_err", 32'(e), 32'd0);
    chk("gap_mem9", 32'(mem[9]), 32'h0000ABCD);
    chk("gap_min2", 32'(min_gap >= 2), 32'd1);

    chk("ack_overlap", 32'(overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
